// File: rtl/hps_pkg.sv
// Shared definitions for the harmonic product spectrum (HPS) pitch path.
//
// Contents:
//   NUM_HPS_BINS  - product beats per analysis frame
//   HPS_FIRST_BIN - spectrum bin number of the first product beat
//   HPS_PROD_W    - width of one HPS product
//   HPS_BIN_W     - width of the reported bin field
//   hps_report_t  - packed pitch report {bin, peak}, bin in the upper bits
//   picker_state_t- peak picker frame states
package hps_pkg;

    localparam int unsigned NUM_HPS_BINS  = 32;
    localparam int unsigned HPS_FIRST_BIN = 2;
    localparam int unsigned HPS_PROD_W    = 48;
    localparam int unsigned HPS_BIN_W     = 8;

    typedef struct packed {
        logic [HPS_BIN_W-1:0]  bin;
        logic [HPS_PROD_W-1:0] peak;
    } hps_report_t;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } picker_state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running arg-max over one frame of unsigned products.
//
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   start      - current beat is the first of a frame (loads unconditionally)
//   valid      - current beat is being accepted
//   idx        - beat index of the current beat
//   data       - product value of the current beat
//   best_val   - largest product so far, including the current beat
//   best_idx   - beat index of best_val (lowest index on ties)
//
// best_val/best_idx already fold in the beat presented this cycle, so the
// owner can latch a final result on the same edge that accepts the last beat.
module argmax_tracker
    import hps_pkg::*;
#(
    parameter int unsigned PROD_W = HPS_PROD_W,
    parameter int unsigned IDX_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              valid,
    input  logic [IDX_W-1:0]  idx,
    input  logic [PROD_W-1:0] data,
    output logic [PROD_W-1:0] best_val,
    output logic [IDX_W-1:0]  best_idx
);

    logic [PROD_W-1:0] val_q;
    logic [IDX_W-1:0]  idx_q;
    logic              take;

    // Strict greater-than keeps the earliest (lowest) bin on ties.
    always_comb begin
        take     = valid && (start || (data > val_q));
        best_val = take ? data : val_q;
        best_idx = take ? idx  : idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= '0;
            idx_q <= '0;
        end else if (take) begin
            val_q <= data;
            idx_q <= idx;
        end
    end

endmodule

// File: rtl/hps_peak_picker.sv
// Reduces each frame of NUM_BINS HPS products to one pitch report holding the
// bin with the largest product and that product's value.
//
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   din_data       - HPS product, one per bin, ascending bin order
//   din_valid      - din_data valid
//   din_ready      - picker accepts a beat (registered, low while reporting)
//   dout_data      - report: [PROD_W+BIN_W-1:PROD_W] = bin, [PROD_W-1:0] = peak
//   dout_valid     - report valid, held with stable data until dout_ready
//   dout_ready     - downstream accepts the report
//   threshold      - minimum peak for a valid pitch (HPS_PEAK_THRESHOLD_EN only)
//   clear_overrun  - clears overrun
//   overrun        - sticky: din_valid seen while din_ready was low
//
// Build option: define HPS_PEAK_THRESHOLD_EN to add the threshold port; a
// peak below threshold is then reported with bin 0 ("no pitch").
module hps_peak_picker
    import hps_pkg::*;
#(
    parameter int unsigned NUM_BINS  = NUM_HPS_BINS,
    parameter int unsigned FIRST_BIN = HPS_FIRST_BIN,
    parameter int unsigned PROD_W    = HPS_PROD_W,
    parameter int unsigned BIN_W     = HPS_BIN_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PROD_W-1:0]       din_data,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [BIN_W+PROD_W-1:0] dout_data,
    output logic                    dout_valid,
    input  logic                    dout_ready,
`ifdef HPS_PEAK_THRESHOLD_EN
    input  logic [PROD_W-1:0]       threshold,
`endif
    input  logic                    clear_overrun,
    output logic                    overrun
);

    localparam int unsigned IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

    picker_state_t state_q, state_d;

    logic [IDX_W-1:0]        beat_count, count_d;
    logic                    din_ready_q;
    logic                    dout_valid_q;
    logic [BIN_W+PROD_W-1:0] report_q;
    logic                    overrun_q;

    logic                    accept;
    logic                    last_beat;
    logic                    latch;
    logic [PROD_W-1:0]       best_val;
    logic [IDX_W-1:0]        best_idx;
    logic [BIN_W-1:0]        report_bin;

    assign accept    = din_valid && din_ready_q;
    assign last_beat = (beat_count == IDX_W'(NUM_BINS - 1));

    argmax_tracker #(
        .PROD_W (PROD_W),
        .IDX_W  (IDX_W)
    ) u_argmax (
        .clk      (clk),
        .reset    (reset),
        .start    (beat_count == '0),
        .valid    (accept),
        .idx      (beat_count),
        .data     (din_data),
        .best_val (best_val),
        .best_idx (best_idx)
    );

    always_comb begin
        report_bin = BIN_W'(best_idx) + BIN_W'(FIRST_BIN);
`ifdef HPS_PEAK_THRESHOLD_EN
        if (best_val < threshold) begin
            report_bin = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        count_d = beat_count;
        latch   = 1'b0;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (last_beat) begin
                        count_d = '0;
                        latch   = 1'b1;
                        state_d = REPORT;
                    end else begin
                        count_d = beat_count + 1'b1;
                    end
                end
            end
            REPORT: begin
                if (dout_valid_q && dout_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Handshake outputs are registered from the next state, so din_ready
    // drops on the same edge that dout_valid rises and vice versa.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACCUM;
            beat_count   <= '0;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            report_q     <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_count   <= count_d;
            din_ready_q  <= (state_d == ACCUM);
            dout_valid_q <= (state_d == REPORT);
            if (latch) begin
                report_q <= {report_bin, best_val};
            end
            // Set takes priority over a same-cycle clear.
            if (din_valid && !din_ready_q) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign din_ready  = din_ready_q;
    assign dout_valid = dout_valid_q;
    assign dout_data  = report_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_hps_peak_picker.sv
module tb_hps_peak_picker;
    import hps_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] din_data;
    logic        din_valid;
    logic        din_ready;
    logic [55:0] dout_data;
    logic        dout_valid;
    logic        dout_ready;
    logic        clear_overrun;
    logic        overrun;
`ifdef HPS_PEAK_THRESHOLD_EN
    logic [47:0] threshold;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [47:0] frame [32];
    logic [55:0] held;

    always #5 clk = ~clk;

    hps_peak_picker #(
        .NUM_BINS  (32),
        .FIRST_BIN (2),
        .PROD_W    (48),
        .BIN_W     (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .din_data      (din_data),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .dout_data     (dout_data),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
`ifdef HPS_PEAK_THRESHOLD_EN
        .threshold     (threshold),
`endif
        .clear_overrun (clear_overrun),
        .overrun       (overrun)
    );

    function automatic logic [55:0] rpt(input logic [7:0] bin, input logic [47:0] peak);
        hps_report_t r;
        r.bin  = bin;
        r.peak = peak;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && din_ready !== 1'b1; i++) tick();
        check(tag, 64'(din_ready), 64'd1);
    endtask

    task automatic fill(input logic [47:0] v);
        for (int k = 0; k < 32; k++) frame[k] = v;
    endtask

    // Streams frame[] with no gaps; checks report latency around beat 31.
    task automatic send_frame(input string tag);
        wait_ready({tag, "_ready"});
        for (int k = 0; k < 32; k++) begin
            din_valid = 1'b1;
            din_data  = frame[k];
            if (k == 31) check({tag, "_prevalid"}, 64'(dout_valid), 64'd0);
            tick();
        end
        din_valid = 1'b0;
        check({tag, "_latency"}, 64'(dout_valid), 64'd1);
        check({tag, "_ready_low"}, 64'(din_ready), 64'd0);
    endtask

    task automatic collect(input string tag, input logic [55:0] exp);
        check({tag, "_valid"}, 64'(dout_valid), 64'd1);
        check({tag, "_data"}, 64'(dout_data), 64'(exp));
        dout_ready = 1'b1;
        check({tag, "_hs_ready"}, 64'(din_ready), 64'd0);
        tick();
        dout_ready = 1'b0;
        check({tag, "_done"}, 64'(dout_valid), 64'd0);
        check({tag, "_reready"}, 64'(din_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        din_data      = '0;
        din_valid     = 1'b0;
        dout_ready    = 1'b0;
        clear_overrun = 1'b0;
`ifdef HPS_PEAK_THRESHOLD_EN
        threshold     = '0;
`endif
        tick();
        tick();
        check("rst_valid",   64'(dout_valid), 64'd0);
        check("rst_data",    64'(dout_data),  64'd0);
        check("rst_ready",   64'(din_ready),  64'd0);
        check("rst_overrun", 64'(overrun),    64'd0);
        reset = 1'b0;
        tick();
        check("rst_ready_rise", 64'(din_ready), 64'd1);

        // Ramp: largest at the last beat
        for (int k = 0; k < 32; k++) frame[k] = 48'(k + 1);
        send_frame("ramp");
        collect("ramp", rpt(8'd33, 48'd32));
        check("ramp_no_overrun", 64'(overrun), 64'd0);

        // Ties keep the lowest bin
        fill('0);
        frame[5]  = 48'hAB_CDEF;
        frame[20] = 48'hAB_CDEF;
        send_frame("ties");
        collect("ties", rpt(8'd7, 48'hAB_CDEF));

        // Full-width compare
        fill('0);
        frame[10] = 48'hFFFF_FFFF_FFFF;
        frame[11] = 48'hFFFF_FFFF_FFFE;
        send_frame("fullw");
        collect("fullw", rpt(8'd12, 48'hFFFF_FFFF_FFFF));

        // Upper bits must dominate
        fill(48'd3);
        frame[4] = 48'h0001_0000_0000;
        frame[9] = 48'h0000_FFFF_FFFF;
        send_frame("hibit");
        collect("hibit", rpt(8'd6, 48'h0001_0000_0000));

        // Stall with dout_ready low; din_valid toggling
        for (int k = 0; k < 32; k++) frame[k] = 48'(32 - k);
        send_frame("stall");
        held = rpt(8'd2, 48'd32);
        for (int i = 0; i < 50; i++) begin
            din_valid     = (i % 2) == 1;
            din_data      = 48'($urandom);
            clear_overrun = (i == 11) || (i == 20);
            tick();
            check("stall_valid", 64'(dout_valid), 64'd1);
            check("stall_data",  64'(dout_data),  64'(held));
            check("stall_ready", 64'(din_ready),  64'd0);
            if (i == 11) check("stall_set_wins", 64'(overrun), 64'd1);
            if (i == 20) check("stall_cleared",  64'(overrun), 64'd0);
            if (i == 21) check("stall_reset",    64'(overrun), 64'd1);
        end
        din_valid     = 1'b0;
        clear_overrun = 1'b0;
        tick();
        check("overrun_sticky", 64'(overrun), 64'd1);
        collect("stall", held);
        check("overrun_after_hs", 64'(overrun), 64'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("overrun_clear", 64'(overrun), 64'd0);
        fill('0);
        frame[5]  = 48'hAB_CDEF;
        frame[20] = 48'hAB_CDEF;
        send_frame("post_stall");
        collect("post_stall", rpt(8'd7, 48'hAB_CDEF));

        // Reset after beat 15 discards the partial frame
        for (int k = 0; k < 16; k++) begin
            din_valid = 1'b1;
            din_data  = 48'hFFFF;
            tick();
        end
        din_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", 64'(dout_valid), 64'd0);
        check("midrst_ready", 64'(din_ready),  64'd0);
        fill(48'd7);
        frame[3] = 48'd500;
        send_frame("midrst");
        collect("midrst", rpt(8'd5, 48'd500));
        tick();
        check("midrst_single", 64'(dout_valid), 64'd0);

        // Reset while a report is pending drops it
        for (int k = 0; k < 32; k++) frame[k] = 48'(k + 1);
        send_frame("rptrst");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rptrst_valid", 64'(dout_valid), 64'd0);
        check("rptrst_data",  64'(dout_data),  64'd0);
        wait_ready("rptrst_ready");

`ifdef HPS_PEAK_THRESHOLD_EN
        threshold = 48'd1000;
        fill(48'd1);
        frame[7] = 48'd999;
        send_frame("thr_below");
        collect("thr_below", rpt(8'd0, 48'd999));
        fill('0);
        frame[0] = 48'd1000;
        send_frame("thr_equal");
        collect("thr_equal", rpt(8'd2, 48'd1000));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
